// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: host-side bus initiator for a cascaded 8259-style PIC.
// On start it writes the ICW1..ICW4/OCW1 init list to the selected PIC. It
// then answers INT_Flag with a two-pulse INTA cycle and captures the vector
// from data_Bus. A pending EOI request is issued as a non-specific OCW2 (0x20).
//
// Ports
//   clk, reset            clock, async active-high reset
//   start                 pulse: latch init words and run the init list
//   icw1..icw4, ocw1      init words, sampled on an accepted start
//   eoi_req               pulse: request a non-specific EOI
//   INT_Flag              interrupt from the master PIC
//   data_Bus              shared bus, driven only during write cycles
//   chip_select, A0       PIC select (active low), register address
//   write_flag, read_flag active-low strobes (read_flag is held high)
//   INTA                  active-low interrupt acknowledge
//   init_done, busy       status
//   vector, vector_valid  captured vector and its one-cycle update strobe
module pic_host_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       eoi_req,
  input  logic       INT_Flag,
  inout  wire  [7:0] data_Bus,
  output logic       chip_select,
  output logic       A0,
  output logic       write_flag,
  output logic       read_flag,
  output logic       INTA,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] vector,
  output logic       vector_valid
);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, W_GAP, READY, ACK1, ACK_GAP, ACK2
  } state_t;

  typedef enum logic [2:0] {S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1} step_t;

  typedef struct packed {
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic [7:0] ocw1;
  } init_words_t;

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  state_t      state, state_n;
  step_t       step, step_nxt;
  init_words_t words;
  logic [CW-1:0] cnt;
  logic        is_eoi, in_service, eoi_pend;
  logic        accept, pulse_last, gap_last, counting, wr_active, ack_busy;
  logic [7:0]  wr_data;
  logic        wr_a0;

  assign accept     = start && (state == IDLE || state == READY);
  assign pulse_last = (cnt == PULSE_LAST);
  assign gap_last   = (cnt == GAP_LAST);
  assign counting   = state inside {W_PULSE, W_GAP, ACK1, ACK_GAP, ACK2};
  assign wr_active  = state inside {W_SETUP, W_PULSE, W_HOLD};
  assign ack_busy   = state inside {ACK1, ACK_GAP, ACK2};

  // Next init step: ICW3 only in cascade mode (icw1[1]==0), ICW4 only when
  // icw1[0] requests it; OCW1 always closes the list.
  always_comb begin
    step_nxt = S_OCW1;
    case (step)
      S_ICW1:  step_nxt = S_ICW2;
      S_ICW2:  step_nxt = !words.icw1[1] ? S_ICW3 : (words.icw1[0] ? S_ICW4 : S_OCW1);
      S_ICW3:  step_nxt = words.icw1[0] ? S_ICW4 : S_OCW1;
      default: step_nxt = S_OCW1;
    endcase
  end

  // Write payload: the EOI write shares the engine with a fixed OCW2 word.
  always_comb begin
    wr_data = 8'h20;
    wr_a0   = 1'b0;
    if (!is_eoi) begin
      wr_a0 = (step != S_ICW1);
      case (step)
        S_ICW1:  wr_data = words.icw1;
        S_ICW2:  wr_data = words.icw2;
        S_ICW3:  wr_data = words.icw3;
        S_ICW4:  wr_data = words.icw4;
        default: wr_data = words.ocw1;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = W_SETUP;
      READY: begin
        if (accept || eoi_pend)          state_n = W_SETUP;
        else if (INT_Flag && !in_service) state_n = ACK1;
      end
      W_SETUP: state_n = W_PULSE;
      W_PULSE: if (pulse_last) state_n = W_HOLD;
      W_HOLD:  state_n = W_GAP;
      W_GAP: begin
        if (gap_last) state_n = (is_eoi || step == S_OCW1) ? READY : W_SETUP;
      end
      ACK1:    if (pulse_last) state_n = ACK_GAP;
      ACK_GAP: if (gap_last)   state_n = ACK2;
      ACK2:    if (pulse_last) state_n = READY;
      default: state_n = IDLE;
    endcase
  end

  // Bus-facing outputs decode straight from state so reset releases them
  // on the same edge, without waiting for a clock.
  assign chip_select = !wr_active;
  assign A0          = wr_active ? wr_a0 : 1'b1;
  assign write_flag  = (state != W_PULSE);
  assign read_flag   = 1'b1;
  assign INTA        = !(state == ACK1 || state == ACK2);
  assign busy        = !(state == IDLE || state == READY);
  assign data_Bus    = wr_active ? wr_data : 8'hzz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      step         <= S_ICW1;
      words        <= '0;
      is_eoi       <= 1'b0;
      init_done    <= 1'b0;
      in_service   <= 1'b0;
      eoi_pend     <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (counting && state_n == state) ? cnt + 1'b1 : '0;
      vector_valid <= 1'b0;

      if (accept) begin
        words      <= '{icw1, icw2, icw3, icw4, ocw1};
        step       <= S_ICW1;
        is_eoi     <= 1'b0;
        init_done  <= 1'b0;
        in_service <= 1'b0;
      end else if (state == READY && eoi_pend) begin
        is_eoi     <= 1'b1;
        in_service <= 1'b0;
      end

      if (state == W_GAP && gap_last && !is_eoi) begin
        if (step == S_OCW1) init_done <= 1'b1;
        else                step      <= step_nxt;
      end

      if (state == ACK2 && pulse_last) begin
        vector       <= data_Bus;
        vector_valid <= 1'b1;
        in_service   <= 1'b1;
      end

      // An EOI only means something while an interrupt is in service or
      // being acknowledged; otherwise the request is dropped.
      if (accept || (state == READY && eoi_pend))
        eoi_pend <= 1'b0;
      else if (eoi_req && state != IDLE && (in_service || ack_busy))
        eoi_pend <= 1'b1;
    end
  end

endmodule
